// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: command/response bundle between the calculator
// sequencer (master) and the arithmetic datapath (slave).
interface calc_sequencer_if;
  logic [2:0]  dp_func;
  logic [7:0]  dp_a;
  logic [7:0]  dp_b;
  logic        dp_start;
  logic        dp_done;
  logic [31:0] dp_result;

  modport master (
    output dp_func,
    output dp_a,
    output dp_b,
    output dp_start,
    input  dp_done,
    input  dp_result
  );

  modport slave (
    input  dp_func,
    input  dp_a,
    input  dp_b,
    input  dp_start,
    output dp_done,
    output dp_result
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: turns a push-button press into one calculator datapath
// operation. The button is synchronized (and optionally debounced), a rising
// edge of the clean level is the accept pulse, and an FSM latches the operands,
// fires dp_start, waits for dp_done with a timeout, and holds the result or
// an error code for the display.
// Optional feature: define CALC_SEQ_DEBOUNCE_EN to insert a DEB_CYCLES
// stability filter between the synchronizer and the edge detector.
module calc_sequencer #(
  parameter int DEB_CYCLES = 10000,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   button,
  input  logic [2:0]             func,
  input  logic [7:0]             num1,
  input  logic [7:0]             num2,
  calc_sequencer_if.master       dp,
  output logic [31:0]            cal_result,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   err
);

  localparam int          TO_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] ERR_CODE = 32'hEEEE_EEEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_lvl_prev;
  logic [TO_W-1:0] r_wait_cnt;
  logic [2:0]      r_dp_func;
  logic [7:0]      r_dp_a;
  logic [7:0]      r_dp_b;
  logic            r_dp_start;
  logic [31:0]     r_cal_result;
  logic            r_busy;
  logic            r_result_valid;
  logic            r_err;
  logic            w_level;
  logic            w_accept;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_deb_level;

  // Debounce: follow the synchronized level only after it has disagreed for
  // DEB_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b0;
    end else if (r_sync2 == r_deb_level) begin
      r_deb_cnt   <= '0;
    end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      r_deb_cnt   <= '0;
      r_deb_level <= r_sync2;
    end else begin
      r_deb_cnt   <= r_deb_cnt + 1'b1;
    end
  end

  assign w_level = r_deb_level;
`else
  assign w_level = r_sync2;
`endif

  // Previous clean level, used to form the one-cycle accept pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl_prev <= 1'b0;
    end else begin
      r_lvl_prev <= w_level;
    end
  end

  assign w_accept = w_level & ~r_lvl_prev;

  // Sequencer FSM with all status and command outputs registered.
  // Status flags are updated on the edge that enters the state they
  // describe, so they always agree with the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_dp_func      <= '0;
      r_dp_a         <= '0;
      r_dp_b         <= '0;
      r_dp_start     <= 1'b0;
      r_cal_result   <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_dp_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_accept) begin
            r_state        <= S_CAPTURE;
            r_busy         <= 1'b1;
            r_err          <= 1'b0;
            r_result_valid <= 1'b0;
          end
        end
        S_CAPTURE: begin
          r_dp_func <= func;
          r_dp_a    <= num1;
          r_dp_b    <= num2;
          // Function codes 6 and 7 are reserved and never reach the datapath.
          if (func == 3'b110 || func == 3'b111) begin
            r_state      <= S_ERR;
            r_err        <= 1'b1;
            r_cal_result <= ERR_CODE;
            r_busy       <= 1'b0;
          end else begin
            r_state    <= S_START;
            r_dp_start <= 1'b1;
          end
        end
        S_START: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          // A completion in the final counted cycle still beats the timeout.
          if (dp.dp_done) begin
            r_state        <= S_DONE;
            r_cal_result   <= dp.dp_result;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
          end else if (r_wait_cnt == TO_W'(TIMEOUT)) begin
            r_state      <= S_ERR;
            r_err        <= 1'b1;
            r_cal_result <= ERR_CODE;
            r_busy       <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dp.dp_func   = r_dp_func;
  assign dp.dp_a      = r_dp_a;
  assign dp.dp_b      = r_dp_b;
  assign dp.dp_start  = r_dp_start;
  assign cal_result   = r_cal_result;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer. A stimulus process
// issues button presses and pushes the expected outcome of each operation;
// a datapath responder answers dp_start after a chosen delay; a monitor pops
// and compares whenever busy falls.
module tb_calc_sequencer;
  localparam int TIMEOUT = 255;
  localparam int DEB     = 16;
`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int HOLD = DEB + 8;
`else
  localparam int HOLD = 4;
`endif

  typedef struct {
    logic [2:0]  f;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        rv;
    logic        er;
    logic [31:0] res;
    int          nstart;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        button = 1'b0;
  logic [2:0]  func = '0;
  logic [7:0]  num1 = '0;
  logic [7:0]  num2 = '0;
  logic [31:0] cal_result;
  logic        busy;
  logic        result_valid;
  logic        err;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb[$];

  int          resp_k    = 1;
  logic        resp_en   = 1'b0;
  logic [31:0] resp_val  = '0;
  logic        resp_busy = 1'b0;

  calc_sequencer_if dp_if ();

  calc_sequencer #(
    .DEB_CYCLES (DEB),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .func         (func),
    .num1         (num1),
    .num2         (num2),
    .dp           (dp_if.master),
    .cal_result   (cal_result),
    .busy         (busy),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endfunction

  // Reference model: outcome of one press from the operation rules alone.
  // k is the number of cycles from the dp_start cycle to the dp_done cycle.
  function automatic exp_t model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                 input int k, input logic en, input logic [31:0] v);
    exp_t e;
    e.f = f; e.a = a; e.b = b;
    if (f >= 3'd6) begin
      e.rv = 1'b0; e.er = 1'b1; e.res = 32'hEEEE_EEEE; e.nstart = 0; e.lat = -1;
    end else if (en && (k <= TIMEOUT + 1)) begin
      e.rv = 1'b1; e.er = 1'b0; e.res = v; e.nstart = 1; e.lat = k + 1;
    end else begin
      e.rv = 1'b0; e.er = 1'b1; e.res = 32'hEEEE_EEEE; e.nstart = 1; e.lat = TIMEOUT + 2;
    end
    return e;
  endfunction

  // Datapath responder.
  initial begin
    dp_if.dp_done   = 1'b0;
    dp_if.dp_result = '0;
    forever begin
      @(negedge clk);
      if (dp_if.dp_start === 1'b1 && resp_en) begin
        resp_busy = 1'b1;
        repeat (resp_k) @(negedge clk);
        dp_if.dp_done   = 1'b1;
        dp_if.dp_result = resp_val;
        @(negedge clk);
        dp_if.dp_done   = 1'b0;
        dp_if.dp_result = $urandom;
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: compare against the scoreboard whenever an operation finishes.
  initial begin : monitor
    int   lat;
    int   nst;
    logic pb;
    exp_t e;
    lat = 0; nst = 0; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pb = 1'b0; nst = 0; lat = 0;
      end else begin
        if (dp_if.dp_start === 1'b1) begin
          nst++;
          lat = 0;
        end else begin
          lat++;
        end
        if (pb && !busy) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("result_valid", {31'd0, result_valid}, {31'd0, e.rv});
            check("err", {31'd0, err}, {31'd0, e.er});
            check("cal_result", cal_result, e.res);
            check("dp_func", {29'd0, dp_if.dp_func}, {29'd0, e.f});
            check("dp_a", {24'd0, dp_if.dp_a}, {24'd0, e.a});
            check("dp_b", {24'd0, dp_if.dp_b}, {24'd0, e.b});
            check("dp_start_count", nst, e.nstart);
            if (e.lat >= 0) check("latency", lat, e.lat);
          end
          nst = 0;
        end
        pb = busy;
      end
    end
  end

  task automatic press();
    button = 1'b1;
    repeat (HOLD) @(negedge clk);
    button = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || resp_busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("idle_bound", {31'd0, guard < 2000}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                        input int k, input logic en, input logic [31:0] v, input bit extra);
    @(negedge clk);
    func = f; num1 = a; num2 = b;
    resp_k = k; resp_en = en; resp_val = v;
    sb.push_back(model(f, a, b, k, en, v));
    press();
    // Operands move after capture; the latched command must not follow them.
    func = 3'($urandom); num1 = 8'($urandom); num2 = 8'($urandom);
    if (extra) press();
    wait_idle();
  endtask

  task automatic reset_mid_wait();
    resp_k = 60; resp_en = 1'b1; resp_val = 32'hDEAD_BEEF;
    func = 3'd1; num1 = 8'h55; num2 = 8'hAA;
    @(negedge clk);
    press();
    repeat (5) @(negedge clk);
    check("in_wait_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dp_a", {24'd0, dp_if.dp_a}, 32'd0);
    check("rst_cal", cal_result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_idle();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_rv", {31'd0, result_valid}, 32'd0);
    check("post_rst_err", {31'd0, err}, 32'd0);
    check("post_rst_cal", cal_result, 32'd0);
  endtask

`ifdef CALC_SEQ_DEBOUNCE_EN
  task automatic bounce_test();
    int cnt;
    @(negedge clk);
    func = 3'd2; num1 = 8'h21; num2 = 8'h43;
    resp_k = 3; resp_en = 1'b1; resp_val = 32'h1234;
    sb.push_back(model(3'd2, 8'h21, 8'h43, 3, 1'b1, 32'h1234));
    for (int i = 0; i < 3; i++) begin
      button = 1'b1; repeat (5) @(negedge clk);
      button = 1'b0; repeat (5) @(negedge clk);
    end
    button = 1'b1;
    cnt = 0;
    while (dp_if.dp_start !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("deb_delay_ok", {31'd0, (cnt >= DEB) && (cnt < 100)}, 32'd1);
    repeat (40) @(negedge clk);
    button = 1'b0;
    repeat (HOLD) @(negedge clk);
    wait_idle();
  endtask
`endif

  // Watchdog.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int r;
    int k;
    logic en;
    int guard;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    check("reset_rv", {31'd0, result_valid}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_cal", cal_result, 32'd0);
    check("reset_dp_start", {31'd0, dp_if.dp_start}, 32'd0);
    check("reset_dp_func", {29'd0, dp_if.dp_func}, 32'd0);
    check("reset_dp_a", {24'd0, dp_if.dp_a}, 32'd0);
    check("reset_dp_b", {24'd0, dp_if.dp_b}, 32'd0);

    run_op(3'd0, 8'h12, 8'h34, 5, 1'b1, 32'h46, 1'b0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    run_op(3'd7, 8'h01, 8'h02, 5, 1'b1, 32'h99, 1'b0);
    run_op(3'd6, 8'h03, 8'h04, 5, 1'b1, 32'h99, 1'b0);
    run_op(3'd3, 8'hF0, 8'h0F, TIMEOUT + 1, 1'b1, 32'hCAFE_0001, 1'b0);
    run_op(3'd4, 8'hA5, 8'h5A, TIMEOUT + 2, 1'b1, 32'hCAFE_0002, 1'b0);
    check("late_done_err_kept", {31'd0, err}, 32'd1);
    check("late_done_cal_kept", cal_result, 32'hEEEE_EEEE);
    check("late_done_rv_kept", {31'd0, result_valid}, 32'd0);
    run_op(3'd1, 8'h77, 8'h88, 1, 1'b0, 32'h0, 1'b0);
    run_op(3'd2, 8'h11, 8'h22, 150, 1'b1, 32'h0BAD_F00D, 1'b1);
    reset_mid_wait();
    run_op(3'd5, 8'h9C, 8'h3E, 1, 1'b1, 32'h0000_5A5A, 1'b0);

    for (int i = 0; i < 16; i++) begin
      r  = $urandom_range(0, 9);
      en = 1'b1;
      if (r < 7)       k = $urandom_range(1, 12);
      else if (r == 7) k = $urandom_range(TIMEOUT - 5, TIMEOUT + 5);
      else if (r == 8) begin k = 1; en = 1'b0; end
      else             k = TIMEOUT + 1;
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), k, en, $urandom, 1'b0);
    end

`ifdef CALC_SEQ_DEBOUNCE_EN
    bounce_test();
`endif

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 10000, consecutive stable cycles for debounced button change (DEBOUNCE_EN only).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles in WAIT before error.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port button  in  1  raw asynchronous push-button, 1 = pressed.
REQ-006 SHALL have port func  in  3  operation select from switches.
REQ-007 SHALL have ports num1, num2  in  8 each  operand switches.
REQ-008 SHALL have ports dp_func  out  3, dp_a  out  8, dp_b  out  8  latched command to calculator datapath.
REQ-009 SHALL have port dp_start  out  1  one-cycle datapath start pulse.
REQ-010 SHALL have port dp_done  in  1  datapath completion pulse.
REQ-011 SHALL have port dp_result  in  32  datapath result, valid in dp_done cycle.
REQ-012 SHALL have port cal_result  out  32  registered result to display.
REQ-013 SHALL have ports busy, result_valid, err  out  1 each  status flags.

Function
REQ-014 SHALL pass button through a 2-flop synchronizer before any use.
REQ-015 SHALL generate a one-cycle accept pulse on each 0->1 transition of the (debounced or synchronized) button level.
REQ-016 SHALL implement FSM states IDLE, CAPTURE, START, WAIT, DONE, ERR.
REQ-017 IDLE/DONE/ERR + accept pulse -> CAPTURE; accept pulses in CAPTURE, START, WAIT SHALL be ignored.
REQ-018 CAPTURE SHALL latch func/num1/num2 into dp_func/dp_a/dp_b, clear err and result_valid; next state START, or ERR if func is 3'b110 or 3'b111 (reserved).
REQ-019 START SHALL assert dp_start for exactly one cycle (two cycles after accept pulse), then -> WAIT.
REQ-020 WAIT SHALL count cycles from 0; on dp_done -> DONE with cal_result <= dp_result at that edge; count reaching TIMEOUT without dp_done -> ERR.
REQ-021 dp_done and timeout in the same cycle: dp_done SHALL win.
REQ-022 dp_done outside WAIT SHALL be ignored (no state or output change).
REQ-023 DONE SHALL hold result_valid = 1 and cal_result until next CAPTURE.
REQ-024 ERR SHALL set err = 1 and cal_result = 32'hEEEE_EEEE until next CAPTURE.
REQ-025 busy SHALL be 1 in CAPTURE, START, WAIT; 0 otherwise.
REQ-026 dp_func/dp_a/dp_b SHALL change only in CAPTURE and stay stable through WAIT.

Reset
REQ-027 rst = 0 SHALL immediately force IDLE, dp_start 0, busy 0, result_valid 0, err 0, cal_result 0, dp_func/dp_a/dp_b 0, synchronizer/debounce/timeout counters 0.
REQ-028 Reset during WAIT SHALL abandon the operation; a later dp_done SHALL be ignored.

Configuration
REQ-029 With CALC_SEQ_DEBOUNCE_EN defined, the debounced level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-030 Without CALC_SEQ_DEBOUNCE_EN, the synchronized level SHALL be used directly and DEB_CYCLES ignored.

Verification
REQ-031 No macro, func=0, num1=8'h12, num2=8'h34, press -> dp_start 1 cycle, dp_a=8'h12, dp_b=8'h34; dp_done with dp_result=32'h46 after 5 cycles -> cal_result=32'h46, result_valid=1, busy=0.
REQ-032 func=3'b111, press -> err=1, cal_result=32'hEEEE_EEEE, dp_start never asserted.
REQ-033 Press, never assert dp_done, TIMEOUT=255 -> ERR entered 255 cycles into WAIT; dp_done at cycle 255 instead -> DONE.
REQ-034 Second press during WAIT -> ignored, one dp_start total; rst low mid-WAIT then dp_done -> outputs stay at reset values.
REQ-035 CALC_SEQ_DEBOUNCE_EN, DEB_CYCLES=16, 3 bounces of 5 cycles then stable high -> exactly one accept pulse, 16+ cycles after last bounce.
